// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: instruction-word layout, kind encodings and FSM state encodings for cpu_sequencer.
package cpu_seq_pkg;
    localparam int WORD_W   = 17;
    localparam int KIND_LSB = 15;
    localparam int OP_LSB   = 8;
    localparam int OP_W     = 7;
    localparam int DATA_W   = 8;

    localparam logic [1:0] K_HALT = 2'b00;
    localparam logic [1:0] K_LOAD = 2'b01;
    localparam logic [1:0] K_OP   = 2'b10;
    localparam logic [1:0] K_RSVD = 2'b11;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;
    localparam logic [2:0] S_END     = 3'd5;
endpackage

// File: rtl/cpu_seq_progmem.sv
// cpu_seq_progmem: single-port program RAM, synchronous write and registered read (write wins).
module cpu_seq_progmem
    import cpu_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        else if (re)
            rdata <= mem[addr];
    end
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: runs a small stored program of LOAD/OP/HALT words against an external CPU.
// Optional CPU_SEQ_STEP_EN adds a step input that gates each instruction fetch.
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int PROG_DEPTH = 16,
    parameter int AW         = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [WORD_W-1:0] prog_wdata,
    input  logic              start,
`ifdef CPU_SEQ_STEP_EN
    input  logic              step,
`endif
    output logic [DATA_W-1:0] cpu_data_in,
    output logic [OP_W-1:0]   cpu_opcode,
    output logic              cpu_cin,
    output logic              cpu_load,
    output logic              cpu_ce,
    input  logic [DATA_W-1:0] cpu_data_out,
    input  logic              cpu_cout,
    output logic [DATA_W-1:0] result,
    output logic              result_cout,
    output logic              result_valid,
    output logic              busy,
    output logic              done,
    output logic              bad_instr
);
    logic [2:0]        state;
    logic [AW-1:0]     pc;
    logic [WORD_W-1:0] word;
    logic [1:0]        kind;
    logic              fetch_go, issuing, is_op, last;
    logic [DATA_W-1:0] data_q;
    logic [OP_W-1:0]   opcode_q;
    logic              cin_q;

`ifdef CPU_SEQ_STEP_EN
    assign fetch_go = step;
`else
    assign fetch_go = 1'b1;
`endif

    cpu_seq_progmem #(.DEPTH(PROG_DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (prog_we && state == S_IDLE),
        .re    (state == S_FETCH && fetch_go),
        .addr  (state == S_IDLE ? prog_addr : pc),
        .wdata (prog_wdata),
        .rdata (word)
    );

    assign kind    = word[KIND_LSB +: 2];
    assign issuing = state == S_ISSUE && kind != K_HALT && kind != K_RSVD;
    assign is_op   = issuing && kind == K_OP;
    assign last    = pc == AW'(PROG_DEPTH - 1);

    // CPU operands pass through during ISSUE and otherwise hold the last issued value
    assign cpu_ce      = issuing;
    assign cpu_load    = issuing && kind == K_LOAD;
    assign cpu_opcode  = issuing ? word[OP_LSB +: OP_W] : opcode_q;
    assign cpu_data_in = cpu_load ? word[DATA_W-1:0] : data_q;
    assign cpu_cin     = is_op ? word[0] : cin_q;
    assign busy        = state != S_IDLE;
    assign done        = state == S_END;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            pc           <= '0;
            data_q       <= '0;
            opcode_q     <= '0;
            cin_q        <= 1'b0;
            result       <= '0;
            result_cout  <= 1'b0;
            result_valid <= 1'b0;
            bad_instr    <= 1'b0;
        end else begin
            data_q       <= cpu_data_in;
            opcode_q     <= cpu_opcode;
            cin_q        <= cpu_cin;
            result_valid <= state == S_CAPTURE;
            case (state)
                S_IDLE: if (start) begin
                    pc        <= '0;
                    bad_instr <= 1'b0;
                    state     <= S_FETCH;
                end
                S_FETCH: if (fetch_go) state <= S_ISSUE;
                S_ISSUE: begin
                    bad_instr <= bad_instr | (kind == K_RSVD);
                    pc        <= (kind == K_LOAD && !last) ? pc + 1'b1 : pc;
                    state     <= kind == K_OP ? S_EXEC : (kind == K_LOAD && !last) ? S_FETCH : S_END;
                end
                S_EXEC: state <= S_CAPTURE;
                S_CAPTURE: begin
                    result      <= cpu_data_out;
                    result_cout <= cpu_cout;
                    pc          <= last ? pc : pc + 1'b1;
                    state       <= last ? S_END : S_FETCH;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
